// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic       pc_write_en;
    logic       if_id_write_en;
    logic       inject_bubble;
    logic       inject_int;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] int_vector;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] if_id_instr;
    logic [3:0] opcode;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] if_id_pc1;
    logic       if_id_valid;
    logic [7:0] imm;
    logic       imm_valid;
    logic [7:0] int_ret_pc;

    modport master (
        input  pc_write_en, if_id_write_en, inject_bubble, inject_int,
        input  branch_taken, branch_target, int_vector, imem_rdata,
        output imem_addr, if_id_instr, opcode, ra, rb, if_id_pc1,
        output if_id_valid, imm, imm_valid, int_ret_pc
    );

    modport slave (
        output pc_write_en, if_id_write_en, inject_bubble, inject_int,
        output branch_taken, branch_target, int_vector, imem_rdata,
        input  imem_addr, if_id_instr, opcode, ra, rb, if_id_pc1,
        input  if_id_valid, imm, imm_valid, int_ret_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch: PC, IF/ID register, immediate and interrupt capture.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [7:0] RESET_VEC = 8'h00,
    parameter logic [7:0] NOP_INSTR = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [3:0] OPC_LDM = 4'd12;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_IMM = 2'd1,
        S_INT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] pc1_q, pc1_d;
    logic       valid_q, valid_d;
    logic [7:0] imm_q, imm_d;
    logic       imm_valid_q, imm_valid_d;
    logic [7:0] int_ret_pc_q, int_ret_pc_d;
    logic [7:0] pc_inc;
    logic       imm_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_VEC;
            instr_q      <= NOP_INSTR;
            pc1_q        <= 8'h00;
            valid_q      <= 1'b0;
            imm_q        <= 8'h00;
            imm_valid_q  <= 1'b0;
            int_ret_pc_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc1_q        <= pc1_d;
            valid_q      <= valid_d;
            imm_q        <= imm_d;
            imm_valid_q  <= imm_valid_d;
            int_ret_pc_q <= int_ret_pc_d;
        end
    end

    always_comb begin
        pc_inc = pc_q + 8'd1;

        if (bus.branch_taken)      pc_d = bus.branch_target;
        else if (bus.inject_int)   pc_d = bus.int_vector;
        else if (!bus.pc_write_en) pc_d = pc_q;
        else                       pc_d = pc_inc;

        instr_d = instr_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (bus.branch_taken) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!bus.if_id_write_en) begin
            instr_d = instr_q;
        end else if (bus.inject_bubble || bus.inject_int) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = bus.imem_rdata;
            valid_d = 1'b1;
            pc1_d   = pc_inc;
        end
    end

    // Decode stalls IF/ID on an opcode-12 instruction so the byte now on the
    // memory bus can be captured as its immediate.
    assign imm_start = valid_q && (instr_q[7:4] == OPC_LDM) && !bus.if_id_write_en;

    always_comb begin
        state_d      = state_q;
        imm_d        = imm_q;
        imm_valid_d  = 1'b0;
        int_ret_pc_d = int_ret_pc_q;
        if (bus.branch_taken) begin
            state_d = S_RUN;
        end else if (bus.inject_int) begin
            int_ret_pc_d = pc_q;
            state_d      = S_INT;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (imm_start) begin
                        imm_d       = bus.imem_rdata;
                        imm_valid_d = 1'b1;
                        state_d     = S_IMM;
                    end
                end
                S_IMM:   state_d = S_RUN;
                S_INT:   state_d = S_RUN;
                default: state_d = S_RUN;
            endcase
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.opcode      = instr_q[7:4];
    assign bus.ra          = instr_q[3:2];
    assign bus.rb          = instr_q[1:0];
    assign bus.if_id_pc1   = pc1_q;
    assign bus.if_id_valid = valid_q;
    assign bus.imm         = imm_q;
    assign bus.imm_valid   = imm_valid_q;
    assign bus.int_ret_pc  = int_ret_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage driven cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_VEC(8'h00), .NOP_INSTR(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    assign bus.imem_rdata = mem[bus.imem_addr];

    typedef struct packed {
        logic       pcw;
        logic       ifw;
        logic       bub;
        logic       intr;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] vec;
    } stim_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] instr;
        logic [7:0] pc1;
        logic       valid;
        logic       imm_valid;
    } obs_t;

    obs_t  sb [$];
    stim_t st [$];
    obs_t  ex [$];
    int    total = 0;
    int    bad   = 0;

    function automatic stim_t mk(input logic pcw, input logic ifw, input logic bub,
                                 input logic intr, input logic br,
                                 input logic [7:0] tgt, input logic [7:0] vec);
        return '{pcw: pcw, ifw: ifw, bub: bub, intr: intr, br: br, tgt: tgt, vec: vec};
    endfunction

    function automatic obs_t ob(input logic [7:0] a, input logic [7:0] i,
                                input logic [7:0] p, input logic v, input logic iv);
        return '{addr: a, instr: i, pc1: p, valid: v, imm_valid: iv};
    endfunction

    function automatic obs_t sample();
        return '{addr: bus.imem_addr, instr: bus.if_id_instr, pc1: bus.if_id_pc1,
                 valid: bus.if_id_valid, imm_valid: bus.imm_valid};
    endfunction

    task automatic drive(input stim_t s);
        bus.pc_write_en    = s.pcw;
        bus.if_id_write_en = s.ifw;
        bus.inject_bubble  = s.bub;
        bus.inject_int     = s.intr;
        bus.branch_taken   = s.br;
        bus.branch_target  = s.tgt;
        bus.int_vector     = s.vec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input stim_t s, input obs_t e);
        st.push_back(s);
        ex.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic reset_dut();
        drive(mk(1, 1, 0, 0, 0, 8'h00, 8'h00));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        st.delete();
        ex.delete();
        sb.delete();
    endtask

    task automatic test_reset();
        obs_t g;
        clear_mem();
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
        reset_dut();
        g = sample();
        total++;
        if (g !== ob(8'h00, 8'h00, 8'h00, 0, 0)) begin
            bad++; $display("FAIL reset_ifid got=%h exp=%h", g, ob(8'h00, 8'h00, 8'h00, 0, 0));
        end
        total++;
        if ({bus.imm, bus.int_ret_pc} !== 16'h0000) begin
            bad++; $display("FAIL reset_imm_ret got=%h exp=0000", {bus.imm, bus.int_ret_pc});
        end
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'h12, 8'h01, 1, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'h34, 8'h02, 1, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h03, 8'h56, 8'h03, 1, 0));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL seq step%0d got=%h exp=%h", k, g, e); end
        end
        total++;
        if ({bus.opcode, bus.ra, bus.rb} !== 8'h56) begin
            bad++; $display("FAIL slices got=%h exp=56", {bus.opcode, bus.ra, bus.rb});
        end
    endtask

    task automatic test_bubble_hold();
        obs_t g;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12;
        reset_dut();
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'h10, 8'h01, 1, 0));
        add(mk(0, 1, 1, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'h11, 8'h02, 1, 0));
        add(mk(0, 0, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'h11, 8'h02, 1, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h03, 8'h12, 8'h03, 1, 0));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL bubble step%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_imm(input logic hold_pc);
        obs_t g;
        clear_mem();
        mem[0] = 8'hC4; mem[1] = 8'h5A; mem[2] = 8'h77;
        reset_dut();
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'hC4, 8'h01, 1, 0));
        if (hold_pc) begin
            add(mk(0, 0, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'hC4, 8'h01, 1, 1));
            add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'h5A, 8'h02, 1, 0));
        end else begin
            add(mk(1, 0, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'hC4, 8'h01, 1, 1));
            add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h03, 8'h77, 8'h03, 1, 0));
        end
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL imm%0d step%0d got=%h exp=%h", hold_pc, k, g, e); end
        end
        total++;
        if (bus.imm !== 8'h5A) begin bad++; $display("FAIL imm_value got=%h exp=5a", bus.imm); end
    endtask

    task automatic test_int();
        obs_t g;
        clear_mem();
        for (int i = 0; i < 7; i++) mem[i] = 8'h10 + 8'(i);
        mem[8'h40] = 8'h21;
        reset_dut();
        for (int i = 0; i < 7; i++)
            add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'(i + 1), 8'h10 + 8'(i), 8'(i + 1), 1, 0));
        add(mk(1, 1, 0, 1, 0, 8'h00, 8'h40), ob(8'h40, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h41, 8'h21, 8'h41, 1, 0));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL int step%0d got=%h exp=%h", k, g, e); end
        end
        total++;
        if (bus.int_ret_pc !== 8'h07) begin bad++; $display("FAIL int_ret got=%h exp=07", bus.int_ret_pc); end
    endtask

    task automatic test_branch_imm();
        obs_t g;
        clear_mem();
        mem[0] = 8'hC4; mem[1] = 8'h5A; mem[8'h20] = 8'h33;
        reset_dut();
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'hC4, 8'h01, 1, 0));
        add(mk(1, 0, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'hC4, 8'h01, 1, 1));
        add(mk(1, 1, 0, 0, 1, 8'h20, 8'h00), ob(8'h20, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h21, 8'h33, 8'h21, 1, 0));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL br_imm step%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_int_branch();
        obs_t g;
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h11; mem[8'h40] = 8'h21; mem[8'h30] = 8'h44;
        reset_dut();
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h01, 8'h10, 8'h01, 1, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h02, 8'h11, 8'h02, 1, 0));
        add(mk(1, 1, 0, 1, 0, 8'h00, 8'h40), ob(8'h40, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h41, 8'h21, 8'h41, 1, 0));
        add(mk(1, 1, 0, 1, 1, 8'h30, 8'h40), ob(8'h30, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'h31, 8'h44, 8'h31, 1, 0));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL int_br step%0d got=%h exp=%h", k, g, e); end
        end
        total++;
        if (bus.int_ret_pc !== 8'h02) begin bad++; $display("FAIL int_br_ret got=%h exp=02", bus.int_ret_pc); end
    endtask

    task automatic test_wrap_reset();
        obs_t g;
        clear_mem();
        mem[8'hFE] = 8'hC4; mem[8'hFF] = 8'h99; mem[0] = 8'h55;
        reset_dut();
        add(mk(1, 1, 0, 0, 1, 8'hFE, 8'h00), ob(8'hFE, 8'h00, 8'h00, 0, 0));
        add(mk(1, 1, 0, 0, 0, 8'h00, 8'h00), ob(8'hFF, 8'hC4, 8'hFF, 1, 0));
        add(mk(1, 0, 0, 0, 0, 8'h00, 8'h00), ob(8'h00, 8'hC4, 8'hFF, 1, 1));
        for (int k = 0; k < st.size(); k++) begin
            obs_t e;
            drive(st[k]); sb.push_back(ex[k]); tick();
            e = sb.pop_front(); g = sample();
            if (!e.valid) g.pc1 = e.pc1;
            total++;
            if (g !== e) begin bad++; $display("FAIL wrap step%0d got=%h exp=%h", k, g, e); end
        end
        total++;
        if (bus.imm !== 8'h99) begin bad++; $display("FAIL wrap_imm got=%h exp=99", bus.imm); end
        // Asynchronous reset in the middle of the immediate cycle.
        drive(mk(1, 1, 0, 0, 0, 8'h00, 8'h00));
        rst = 1'b1;
        #2;
        g = sample();
        total++;
        if (g !== ob(8'h00, 8'h00, 8'h00, 0, 0)) begin
            bad++; $display("FAIL async_rst got=%h exp=%h", g, ob(8'h00, 8'h00, 8'h00, 0, 0));
        end
        total++;
        if ({bus.imm, bus.int_ret_pc} !== 16'h0000) begin
            bad++; $display("FAIL async_rst_imm got=%h exp=0000", {bus.imm, bus.int_ret_pc});
        end
        tick();
        rst = 1'b0;
        tick();
        g = sample();
        total++;
        if (g !== ob(8'h01, 8'h55, 8'h01, 1, 0)) begin
            bad++; $display("FAIL post_rst got=%h exp=%h", g, ob(8'h01, 8'h55, 8'h01, 1, 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bubble_hold();
        test_imm(1'b0);
        test_imm(1'b1);
        test_int();
        test_branch_imm();
        test_int_branch();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
